// File: rtl/usb_tx_crc16_gen_if.sv
// Bit-level handshake bundle between the TX byte serializer and the CRC16
// generator, and on to the NRZI/bit-stuff stage.
// Ports: master drives packet control and payload bits; slave is the CRC generator.
interface usb_tx_crc16_gen_if;
  logic crc_clear;     // start of packet, 1-cycle pulse
  logic shift_enable;  // bit-time strobe
  logic payload_bit;   // payload bit, sampled with shift_enable in DATA
  logic crc_start;     // end of payload, switch to CRC emission
  logic tx_bit;        // registered serial bit to the bit-stuffer
  logic tx_bit_valid;  // 1-cycle pulse per new tx_bit
  logic crc_busy;      // packet in progress (DATA or CRC)
  logic crc_done;      // pulses with the 16th CRC bit
  logic crc_self_ok;   // loopback self-check result

  modport master (
    output crc_clear, shift_enable, payload_bit, crc_start,
    input  tx_bit, tx_bit_valid, crc_busy, crc_done, crc_self_ok
  );

  modport slave (
    input  crc_clear, shift_enable, payload_bit, crc_start,
    output tx_bit, tx_bit_valid, crc_busy, crc_done, crc_self_ok
  );
endinterface

// File: rtl/usb_tx_crc16_gen.sv
// Transmit-side USB CRC16 generator (x^16+x^15+x^2+1, preset 0xFFFF): passes
// payload bits through, then appends the inverted CRC MSB first.
// Ports: clk, n_rst (async active-low), bus (usb_tx_crc16_gen_if.slave).
// Latency: one clk from an accepted shift_enable to the tx_bit_valid pulse.
// Optional macro USB_TX_CRC_SELFCHECK_EN adds a loopback checker driving crc_self_ok.
module usb_tx_crc16_gen #(
  parameter logic [15:0] CRC_INIT = 16'hFFFF,
  parameter logic [15:0] CRC_POLY = 16'h8005
) (
  input  logic               clk,
  input  logic               n_rst,
  usb_tx_crc16_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_CRC  = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] q_q;
  logic [3:0]  cnt_q;
  logic        tx_bit_q;
  logic        tx_vld_q;
  logic        busy_q;
  logic        done_q;

  // One serial step of the CRC LFSR, MSB-first.
  function automatic logic [15:0] crc_step(input logic [15:0] cur, input logic b);
    crc_step = {cur[14:0], 1'b0} ^ ((b ^ cur[15]) ? CRC_POLY : 16'h0000);
  endfunction

  // Bit actually being emitted this cycle (data or inverted CRC), shared by
  // the main path and the optional loopback checker.
  logic emit_vld;
  logic emit_bit;
  logic emit_last;

  always_comb begin
    emit_vld  = 1'b0;
    emit_bit  = 1'b0;
    emit_last = 1'b0;
    if (!bus.crc_clear && bus.shift_enable) begin
      if (state_q == ST_DATA) begin
        emit_vld = 1'b1;
        emit_bit = bus.payload_bit;
      end else if (state_q == ST_CRC) begin
        emit_vld  = 1'b1;
        emit_bit  = ~q_q[15];
        emit_last = (cnt_q == 4'd15);
      end
    end
  end

  // Single FSM; all outputs are registered. crc_clear wins in every state.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q  <= ST_IDLE;
      q_q      <= CRC_INIT;
      cnt_q    <= 4'd0;
      tx_bit_q <= 1'b1;
      tx_vld_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      tx_vld_q <= 1'b0;
      done_q   <= 1'b0;
      if (bus.crc_clear) begin
        state_q <= ST_DATA;
        q_q     <= CRC_INIT;
        cnt_q   <= 4'd0;
        busy_q  <= 1'b1;
      end else begin
        case (state_q)
          ST_DATA: begin
            // A payload bit arriving with crc_start is still consumed.
            if (bus.shift_enable) begin
              q_q      <= crc_step(q_q, bus.payload_bit);
              tx_bit_q <= bus.payload_bit;
              tx_vld_q <= 1'b1;
            end
            if (bus.crc_start) begin
              state_q <= ST_CRC;
            end
          end
          ST_CRC: begin
            // Shifting ones in behind the CRC keeps q meaningless afterwards
            // but harmless; it is re-preset on the next crc_clear.
            if (bus.shift_enable) begin
              tx_bit_q <= ~q_q[15];
              tx_vld_q <= 1'b1;
              q_q      <= {q_q[14:0], 1'b1};
              if (cnt_q == 4'd15) begin
                cnt_q   <= 4'd0;
                state_q <= ST_IDLE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                cnt_q <= cnt_q + 4'd1;
              end
            end
          end
          default: begin
            // IDLE: inputs other than crc_clear are ignored, tx_bit holds.
          end
        endcase
      end
    end
  end

  assign bus.tx_bit       = tx_bit_q;
  assign bus.tx_bit_valid = tx_vld_q;
  assign bus.crc_busy     = busy_q;
  assign bus.crc_done     = done_q;

`ifdef USB_TX_CRC_SELFCHECK_EN
  // Far-end model: a second LFSR fed by every emitted bit. A correct
  // payload+inverted-CRC stream leaves it on the fixed residual 0x800D.
  logic [15:0] chk_q;
  logic [15:0] chk_d;
  logic        self_ok_q;

  always_comb begin
    chk_d = chk_q;
    if (emit_vld) begin
      chk_d = crc_step(chk_q, emit_bit);
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      chk_q     <= CRC_INIT;
      self_ok_q <= 1'b0;
    end else if (bus.crc_clear) begin
      chk_q     <= CRC_INIT;
      self_ok_q <= 1'b0;
    end else begin
      chk_q <= chk_d;
      if (emit_last) begin
        self_ok_q <= (chk_d == 16'h800D);
      end
    end
  end

  assign bus.crc_self_ok = self_ok_q;
`else
  // Without the checker the emit decode only feeds nothing; keep it observable
  // through a reduction so it is not flagged as dead logic.
  logic emit_unused;
  assign emit_unused     = emit_vld & emit_bit & emit_last;
  assign bus.crc_self_ok = 1'b0 & emit_unused;
`endif

endmodule

// File: tb/tb_usb_tx_crc16_gen.sv
module tb_usb_tx_crc16_gen;

  logic clk;
  logic n_rst;

  usb_tx_crc16_gen_if bus ();

  usb_tx_crc16_gen dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef USB_TX_CRC_SELFCHECK_EN
  localparam logic EXP_OK = 1'b1;
`else
  localparam logic EXP_OK = 1'b0;
`endif

  typedef struct {
    logic b;
    logic done;
    logic ok;
  } exp_t;

  exp_t        exp_q[$];
  int          checks;
  int          failures;
  int          valid_seen;
  logic [15:0] ref_q;   // far-end reference checker fed by observed tx_bits
  logic [15:0] mq;      // bench CRC model for generated payloads

  function automatic logic [15:0] crc_step(input logic [15:0] cur, input logic b);
    logic fb;
    fb = b ^ cur[15];
    crc_step = {cur[14:0], 1'b0};
    if (fb) crc_step = crc_step ^ 16'h8005;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops an expectation for every tx_bit_valid pulse.
  always @(negedge clk) begin
    if (n_rst) begin
      if (bus.tx_bit_valid) begin
        valid_seen++;
        ref_q = crc_step(ref_q, bus.tx_bit);
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid actual=tx_bit %b required=no pulse", bus.tx_bit);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (bus.tx_bit !== e.b || bus.crc_done !== e.done) begin
            failures++;
            $display("FAIL tx_bit actual=%b/done %b required=%b/done %b",
                     bus.tx_bit, bus.crc_done, e.b, e.done);
          end
          if (e.done) begin
            checks++;
            if (ref_q !== 16'h800D) begin
              failures++;
              $display("FAIL residual actual=%h required=800d", ref_q);
            end
            checks++;
            if (bus.crc_self_ok !== e.ok) begin
              failures++;
              $display("FAIL self_ok actual=%b required=%b", bus.crc_self_ok, e.ok);
            end
          end
        end
      end else if (bus.crc_done) begin
        checks++;
        failures++;
        $display("FAIL done_without_valid actual=1 required=0");
      end
      if (bus.crc_clear) ref_q = 16'hFFFF;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    bus.crc_clear = 1'b1;
    tick();
    bus.crc_clear = 1'b0;
    mq = 16'hFFFF;
  endtask

  task automatic send_bit(input logic b, input logic with_start);
    exp_t e;
    e.b = b; e.done = 1'b0; e.ok = 1'b0;
    exp_q.push_back(e);
    mq = crc_step(mq, b);
    bus.payload_bit  = b;
    bus.shift_enable = 1'b1;
    bus.crc_start    = with_start;
    tick();
    bus.shift_enable = 1'b0;
    bus.crc_start    = 1'b0;
    tick();
  endtask

  task automatic do_start();
    bus.crc_start = 1'b1;
    tick();
    bus.crc_start = 1'b0;
  endtask

  // Emits n CRC bits; expected bits are the given 16-bit word, MSB first.
  task automatic emit_crc(input logic [15:0] crc, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.b = crc[15-i]; e.done = (i == 15); e.ok = EXP_OK;
      exp_q.push_back(e);
      bus.shift_enable = 1'b1;
      tick();
      bus.shift_enable = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout actual=%0d pending required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) tick();
  endtask

  initial begin
    logic [63:0] pay;
    logic [7:0]  abort_byte;
    int          vs;

    checks = 0; failures = 0; valid_seen = 0;
    ref_q = 16'hFFFF; mq = 16'hFFFF;
    bus.crc_clear = 1'b0; bus.shift_enable = 1'b0;
    bus.payload_bit = 1'b0; bus.crc_start = 1'b0;
    n_rst = 1'b0;

    // Reset held: inputs toggling must not disturb reset values.
    repeat (2) tick();
    bus.shift_enable = 1'b1; bus.crc_clear = 1'b1; bus.crc_start = 1'b1;
    repeat (3) tick();
    bus.shift_enable = 1'b0; bus.crc_clear = 1'b0; bus.crc_start = 1'b0;
    chk("rst_tx_bit", {15'd0, bus.tx_bit}, 16'd1);
    chk("rst_valid",  {15'd0, bus.tx_bit_valid}, 16'd0);
    chk("rst_busy",   {15'd0, bus.crc_busy}, 16'd0);
    chk("rst_done",   {15'd0, bus.crc_done}, 16'd0);
    chk("rst_self_ok",{15'd0, bus.crc_self_ok}, 16'd0);
    n_rst = 1'b1;
    tick();

    // IDLE: shifts and crc_start ignored.
    for (int i = 0; i < 4; i++) begin
      bus.shift_enable = 1'b1; bus.payload_bit = i[0]; bus.crc_start = (i == 2);
      tick();
      bus.shift_enable = 1'b0; bus.crc_start = 1'b0;
      tick();
    end
    tick();
    chk("idle_no_valid", valid_seen[15:0], 16'd0);
    chk("idle_busy", {15'd0, bus.crc_busy}, 16'd0);
    chk("idle_tx_bit", {15'd0, bus.tx_bit}, 16'd1);

    // Zero-length packet: inverted preset = 16 zeros.
    do_clear();
    chk("zl_busy", {15'd0, bus.crc_busy}, 16'd1);
    do_start();
    emit_crc(16'h0000, 16, 1);
    drain("zero_len");
    chk("zl_busy_end", {15'd0, bus.crc_busy}, 16'd0);

    // Single '0' payload bit: q=0x7FFB, emitted CRC 0x8004.
    do_clear();
    send_bit(1'b0, 1'b0);
    do_start();
    emit_crc(16'h8004, 16, 2);
    drain("one_bit");

    // 8-byte payload, MSB first per byte.
    pay = 64'h3AC50F9671E25BD4;
    do_clear();
    for (int i = 63; i >= 0; i--) send_bit(pay[i], 1'b0);
    do_start();
    emit_crc(~mq, 16, 0);
    drain("eight_byte");

    // Abort mid-CRC after 5 bits, then a fresh single-bit packet.
    abort_byte = 8'hA5;
    do_clear();
    for (int i = 7; i >= 0; i--) send_bit(abort_byte[i], 1'b0);
    do_start();
    emit_crc(~mq, 5, 1);
    do_clear();
    chk("abort_busy", {15'd0, bus.crc_busy}, 16'd1);
    vs = valid_seen;
    repeat (4) tick();
    chk("abort_no_emit", 16'(valid_seen - vs), 16'd0);
    send_bit(1'b0, 1'b0);
    do_start();
    emit_crc(16'h8004, 16, 1);
    drain("after_abort");

    // crc_start together with the last payload bit.
    do_clear();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    repeat (3) tick();
    emit_crc(~mq, 16, 1);
    drain("same_cycle");
    chk("end_busy", {15'd0, bus.crc_busy}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
